lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Owns the character-LCD bus (E, RS, RW, DATA) and shares it between NUM_REQ display producers, e.g. clock face, alarm editor and stopwatch.
- After reset it runs the LCD power-up and init sequence itself. It then grants the bus byte by byte, in round-robin order.
- A requester can lock the bus to write a whole frame atomically.
- Every byte gets an explicit setup/strobe/hold on E. Clear (0x01) and home (0x02) commands get an extra settle wait.

Parameters:
- NUM_REQ, 2: number of requesters (>=2).
- POWERUP_WAIT, 70: idle cycles after reset before the first init command.
- CLEAR_WAIT, 5: extra bus-idle cycles after any RS=0 byte equal to 0x01 or 0x02.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte pending; held until req_ready[i]
- req_rs  in  NUM_REQ  RS for requester i's byte (0 = command, 1 = data)
- req_data  in  8*NUM_REQ  byte for requester i, in bits [8i+7:8i]
- req_lock  in  NUM_REQ  requester i asks to keep the bus after this byte
- req_ready  out  NUM_REQ  one-cycle pulse when requester i's byte is accepted
- grant  out  NUM_REQ  one-hot current bus owner; 0 when free
- init_done  out  1  high once init completes; sticky until reset
- E  out  1  LCD enable strobe
- RS  out  1  LCD register select
- RW  out  1  LCD read/write; always 0 during transfers
- DATA  out  8  LCD data bus

Behaviour:
- Reset (synchronous, at a clock edge with reset=1):
  - Outputs: E=0, RS=1, RW=1, DATA=0x00, req_ready=0, grant=0, init_done=0.
  - Internal: lock cleared, round-robin pointer set to requester 0, FSM to PWRUP.
  - Reset mid-transfer or mid-init aborts immediately and the whole sequence restarts. No partial byte completes.
- Idle bus value: RS=1, RW=1, DATA=0x00, E=0. Driven in PWRUP, WAIT and ARB.
- FSM states: PWRUP, SETUP, STROBE, HOLD, WAIT, ARB.
- PWRUP:
  - Stays POWERUP_WAIT cycles, counting from the first cycle after reset deasserts.
  - Then goes to SETUP with init byte 0.
- Init sequence:
  - Four bytes, all RS=0: 0x38, 0x0C, 0x06, 0x01.
  - Back-to-back with no ARB cycle in between.
  - The 0x01 is followed by WAIT.
  - At WAIT exit, init_done becomes 1 and the FSM enters ARB.
  - req_ready stays 0 throughout init.
- Transfer, 3 cycles, outputs registered:
  - SETUP: RS and DATA = captured byte, RW=0, E=0.
  - STROBE: same bus values, E=1.
  - HOLD: same bus values, E=0.
- After HOLD:
  - If RS=0 and DATA is 0x01 or 0x02, go to WAIT for CLEAR_WAIT cycles (bus idle), then to ARB or the next init byte.
  - Otherwise go to ARB or the next init byte directly.
- ARB, 1 cycle:
  - If lock is active for owner k:
    - Only requester k is considered; others wait.
    - If req_lock[k]=0 and req_valid[k]=0, release the lock, set grant=0, and arbitrate normally in the same cycle.
  - Otherwise, round robin: search from pointer p upward, wrapping. The first valid requester i wins.
  - On a win:
    - req_ready[i]=1 for that cycle only.
    - Byte, RS and req_lock[i] are captured; grant becomes onehot(i).
    - Pointer p becomes (i+1) mod NUM_REQ.
    - Next state is SETUP.
  - With no valid requester: stay in ARB, grant=0 unless locked.
- Lock rules:
  - Lock is set when an accepted byte had req_lock=1.
  - Lock is cleared when an accepted byte from the owner had req_lock=0.
  - grant holds onehot(owner) through SETUP..WAIT and while locked. Otherwise it is 0 in ARB.
- Throughput: 4 cycles per byte back-to-back (ARB+SETUP+STROBE+HOLD), plus CLEAR_WAIT after clear/home.
- Simultaneous events:
  - Lower index wins only when the pointer favours it. Each requester gets at most one byte per round when unlocked.
  - req_valid changes during a transfer are ignored until the next ARB.
  - A requester deasserting req_valid before ready: its byte is dropped silently (no error).

Test Plan:
- Init timing (POWERUP_WAIT=4, CLEAR_WAIT=3; cycle 0 = first cycle after reset drops) -> E=1 exactly in cycles 5, 8, 11, 14 with DATA 0x38, 0x0C, 0x06, 0x01, RS=0, RW=0; init_done=1 from cycle 19; req_ready=0 before cycle 19 even with req_valid=11.
- Single write: req0 valid, rs=1, data 0x4B at an ARB cycle t -> req_ready[0]=1 at t; RS=1, DATA=0x4B over t+1..t+3 with E=1 only at t+2; grant=01 over t..t+3, then 00.
- Contention: req_valid=11 held, both unlocked, pointer 0 -> accept order 0, 1, 0, 1 with ready pulses 4 cycles apart; grant alternates 01, 10.
- Lock: req1 sends 3 bytes with lock=1, 1, 0 while req0 stays valid -> the 3 bytes from req1 go consecutively, grant=10 throughout, then req0 is served next.
- Clear command: req0 rs=0, data 0x01 accepted at t -> bus idle t+4..t+6; next ready not before t+7. Same with 0x02; 0x80 gives no wait.
- Reset at the STROBE cycle of a user byte -> next cycle all outputs at reset values, grant=0, lock gone; init sequence repeats with identical timing.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus owner: runs the power-up/init sequence, then hands the bus
// out byte by byte in round-robin order, with optional per-requester frame lock.
module lcd_bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int POWERUP_WAIT = 70,
  parameter int CLEAR_WAIT   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 init_done,
  output logic                 E,
  output logic                 RS,
  output logic                 RW,
  output logic [7:0]           DATA
);
  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (POWERUP_WAIT > CLEAR_WAIT) ? POWERUP_WAIT : CLEAR_WAIT;
  localparam int CW   = $clog2(CMAX + 1) + 1;
  localparam logic [CW-1:0] PW_LAST = CW'((POWERUP_WAIT > 0) ? POWERUP_WAIT - 1 : 0);
  localparam logic [CW-1:0] CL_LAST = CW'((CLEAR_WAIT > 0) ? CLEAR_WAIT - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {PWRUP, SETUP, STROBE, HOLD, WAIT, ARB} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      init_idx, idx_nxt;
  logic            done_nxt, lock, lock_nxt, advance, found, settle;
  logic [IW-1:0]   owner, owner_nxt, ptr, ptr_nxt, win;
  logic            cur_rs, rs_nxt;
  logic [7:0]      cur_data, data_nxt;
  logic [NUM_REQ-1:0] cand;
  int              j;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // clear/home commands need extra settle time on the panel
  assign settle = !cur_rs && (cur_data == 8'h01 || cur_data == 8'h02) && (CLEAR_WAIT > 0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = init_idx;
    done_nxt  = init_done;
    lock_nxt  = lock;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    rs_nxt    = cur_rs;
    data_nxt  = cur_data;
    req_ready = '0;
    grant     = '0;
    advance   = 1'b0;
    cand      = req_valid;
    found     = 1'b0;
    win       = '0;
    j         = 0;
    case (state)
      PWRUP: begin
        if (cnt == PW_LAST) begin
          state_nxt = SETUP;
          idx_nxt   = 2'd0;
          rs_nxt    = 1'b0;
          data_nxt  = init_byte(2'd0);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = HOLD;
      HOLD: begin
        if (settle) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else begin
          advance = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CL_LAST) advance = 1'b1;
        else cnt_nxt = cnt + 1'b1;
      end
      ARB: begin
        // a locked owner that has gone quiet gives the bus back this same cycle
        if (lock) begin
          if (!req_valid[owner] && !req_lock[owner]) lock_nxt = 1'b0;
          else cand = req_valid & (ONE << owner);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
          j = int'(ptr) + k;
          if (j >= NUM_REQ) j = j - NUM_REQ;
          if (!found && cand[j]) begin
            found = 1'b1;
            win   = IW'(j);
          end
        end
        if (found) begin
          req_ready = ONE << win;
          grant     = ONE << win;
          rs_nxt    = req_rs[win];
          data_nxt  = req_data[8*win +: 8];
          lock_nxt  = req_lock[win];
          owner_nxt = win;
          ptr_nxt   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_nxt = SETUP;
        end else if (lock_nxt) begin
          grant = ONE << owner;
        end
      end
      default: state_nxt = PWRUP;
    endcase
    if (init_done && state inside {SETUP, STROBE, HOLD, WAIT}) grant = ONE << owner;
    if (advance) begin
      if (!init_done && init_idx != 2'd3) begin
        state_nxt = SETUP;
        idx_nxt   = init_idx + 2'd1;
        rs_nxt    = 1'b0;
        data_nxt  = init_byte(init_idx + 2'd1);
      end else begin
        state_nxt = ARB;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= PWRUP;
      cnt       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      lock      <= 1'b0;
      owner     <= '0;
      ptr       <= '0;
      cur_rs    <= 1'b1;
      cur_data  <= 8'h00;
      E         <= 1'b0;
      RS        <= 1'b1;
      RW        <= 1'b1;
      DATA      <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_idx  <= idx_nxt;
      init_done <= done_nxt;
      lock      <= lock_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      cur_rs    <= rs_nxt;
      cur_data  <= data_nxt;
      if (state_nxt inside {SETUP, STROBE, HOLD}) begin
        E    <= (state_nxt == STROBE);
        RS   <= rs_nxt;
        RW   <= 1'b0;
        DATA <= data_nxt;
      end else begin
        E    <= 1'b0;
        RS   <= 1'b1;
        RW   <= 1'b1;
        DATA <= 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: expected strobes/accepts are queued with
// their cycle numbers and a monitor compares them as the DUT produces them.
module tb_lcd_bus_arbiter;
  logic        clock, reset;
  logic [1:0]  req_valid, req_rs, req_lock, req_ready, grant;
  logic [15:0] req_data;
  logic        init_done, E, RS, RW;
  logic [7:0]  DATA;

  lcd_bus_arbiter #(.NUM_REQ(2), .POWERUP_WAIT(4), .CLEAR_WAIT(3)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
    .grant(grant), .init_done(init_done), .E(E), .RS(RS), .RW(RW), .DATA(DATA));

  typedef struct {logic rs; logic [7:0] data; logic lk;} tx_t;
  typedef struct {int cyc; logic rs; logic [7:0] data; logic [1:0] gnt;} stb_t;
  typedef struct {int cyc; logic [1:0] rdy;} acc_t;

  tx_t  txq0[$], txq1[$];
  stb_t exp_s[$];
  acc_t exp_a[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // cycle 0 is the first cycle after the reset edge
  always @(posedge clock) begin
    cyc   <= reset ? 0 : cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tx(input int i, input logic rs, input logic [7:0] d, input logic lk);
    tx_t t;
    t.rs = rs; t.data = d; t.lk = lk;
    if (i == 0) txq0.push_back(t);
    else txq1.push_back(t);
  endtask

  task automatic exp_strobe(input int c, input logic rs, input logic [7:0] d, input logic [1:0] g);
    stb_t s;
    s.cyc = c; s.rs = rs; s.data = d; s.gnt = g;
    exp_s.push_back(s);
  endtask

  task automatic exp_acc(input int c, input logic [1:0] r);
    acc_t a;
    a.cyc = c; a.rdy = r;
    exp_a.push_back(a);
  endtask

  task automatic load(input int i);
    tx_t  t;
    logic have = 1'b0;
    if (i == 0 && txq0.size() > 0) begin t = txq0.pop_front(); have = 1'b1; end
    if (i == 1 && txq1.size() > 0) begin t = txq1.pop_front(); have = 1'b1; end
    req_valid[i] = have;
    if (have) begin
      req_rs[i]          = t.rs;
      req_data[8*i +: 8] = t.data;
      req_lock[i]        = t.lk;
    end
  endtask

  // requester driver: hold each byte until its ready pulse, then present the next
  initial begin
    logic [1:0] acc;
    forever begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++)
        if (acc[i] || !req_valid[i]) load(i);
    end
  end

  // monitor: compares every strobe, the hold cycle after it, and every ready pulse
  initial begin
    logic       hold_pend = 1'b0;
    logic       h_rs = 1'b0;
    logic [7:0] h_data = 8'h00;
    stb_t       s;
    acc_t       a;
    forever begin
      @(negedge clock);
      if (hold_pend && !rst_q)
        chk("hold", {21'b0, E, RW, RS, DATA}, {21'b0, 1'b0, 1'b0, h_rs, h_data});
      hold_pend = 1'b0;
      if (E) begin
        if (exp_s.size() == 0) chk("unexpected_strobe", {24'b0, DATA}, 32'hFFFF_FFFF);
        else begin
          s = exp_s.pop_front();
          chk("strobe", {16'(cyc), 4'b0, RW, RS, DATA, grant},
                        {16'(s.cyc), 4'b0, 1'b0, s.rs, s.data, s.gnt});
        end
        hold_pend = 1'b1; h_rs = RS; h_data = DATA;
      end
      if (req_ready != 2'b00) begin
        if (exp_a.size() == 0) chk("unexpected_ready", {30'b0, req_ready}, 32'hFFFF_FFFF);
        else begin
          a = exp_a.pop_front();
          chk("ready", {16'(cyc), 14'b0, req_ready}, {16'(a.cyc), 14'b0, a.rdy});
        end
      end
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic goto(input int n);
    int guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (cyc != n && guard < 400);
    if (cyc != n) begin
      tests++; fails++;
      $display("FAIL goto: cycle %0d not reached, at %0d", n, cyc);
      finish_run();
    end
  endtask

  task automatic do_reset();
    exp_strobe(5, 1'b0, 8'h38, 2'b00);
    exp_strobe(8, 1'b0, 8'h0C, 2'b00);
    exp_strobe(11, 1'b0, 8'h06, 2'b00);
    exp_strobe(14, 1'b0, 8'h01, 2'b00);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    goto(0);
    chk("reset_state", {16'b0, E, RS, RW, DATA, grant, req_ready, init_done},
                       {16'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 2'b00, 1'b0});
  endtask

  task automatic check_init_done();
    goto(18);
    chk("init_done_c18", {31'b0, init_done}, 32'd0);
    goto(19);
    chk("init_done_c19", {31'b0, init_done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_rs = '0; req_lock = '0; req_data = '0;
    do_reset();
    // contention, both requesters valid from cycle 1 (during init)
    tx(0, 1'b1, 8'h41, 1'b0); tx(0, 1'b1, 8'h42, 1'b0);
    tx(1, 1'b1, 8'h61, 1'b0); tx(1, 1'b1, 8'h62, 1'b0);
    exp_acc(19, 2'b01); exp_acc(23, 2'b10); exp_acc(27, 2'b01); exp_acc(31, 2'b10);
    exp_strobe(21, 1'b1, 8'h41, 2'b01); exp_strobe(25, 1'b1, 8'h61, 2'b10);
    exp_strobe(29, 1'b1, 8'h42, 2'b01); exp_strobe(33, 1'b1, 8'h62, 2'b10);
    check_init_done();
    // single write
    goto(40);
    tx(0, 1'b1, 8'h4B, 1'b0);
    exp_acc(41, 2'b01); exp_strobe(43, 1'b1, 8'h4B, 2'b01);
    goto(44); chk("grant_hold", {30'b0, grant}, 32'd1);
    goto(45); chk("grant_free", {30'b0, grant}, 32'd0);
    // clear: settle wait before next accept
    goto(50);
    tx(0, 1'b0, 8'h01, 1'b0); tx(0, 1'b1, 8'h55, 1'b0);
    exp_acc(51, 2'b01); exp_acc(58, 2'b01);
    exp_strobe(53, 1'b0, 8'h01, 2'b01); exp_strobe(60, 1'b1, 8'h55, 2'b01);
    goto(56);
    chk("wait_idle_bus", {21'b0, E, RS, RW, DATA}, {21'b0, 1'b0, 1'b1, 1'b1, 8'h00});
    chk("wait_grant", {30'b0, grant}, 32'd1);
    // home
    goto(70);
    tx(0, 1'b0, 8'h02, 1'b0); tx(0, 1'b1, 8'h56, 1'b0);
    exp_acc(71, 2'b01); exp_acc(78, 2'b01);
    exp_strobe(73, 1'b0, 8'h02, 2'b01); exp_strobe(80, 1'b1, 8'h56, 2'b01);
    // ordinary command: no wait
    goto(90);
    tx(0, 1'b0, 8'h80, 1'b0); tx(0, 1'b1, 8'h57, 1'b0);
    exp_acc(91, 2'b01); exp_acc(95, 2'b01);
    exp_strobe(93, 1'b0, 8'h80, 2'b01); exp_strobe(97, 1'b1, 8'h57, 2'b01);
    // lock: req1 frame of three bytes keeps req0 out
    goto(100);
    tx(1, 1'b1, 8'h71, 1'b1); tx(1, 1'b1, 8'h72, 1'b1); tx(1, 1'b1, 8'h73, 1'b0);
    exp_acc(101, 2'b10); exp_acc(105, 2'b10); exp_acc(109, 2'b10); exp_acc(113, 2'b01);
    exp_strobe(103, 1'b1, 8'h71, 2'b10); exp_strobe(107, 1'b1, 8'h72, 2'b10);
    exp_strobe(111, 1'b1, 8'h73, 2'b10); exp_strobe(115, 1'b1, 8'h31, 2'b01);
    goto(101);
    tx(0, 1'b1, 8'h31, 1'b0);
    goto(108); chk("lock_grant", {30'b0, grant}, 32'd2);
    // reset in the strobe cycle of a user byte
    goto(120);
    tx(0, 1'b1, 8'h5A, 1'b0);
    exp_acc(121, 2'b01); exp_strobe(123, 1'b1, 8'h5A, 2'b01);
    goto(123);
    do_reset();
    check_init_done();
    // pointer back at 0 after reset
    goto(20);
    tx(0, 1'b1, 8'h91, 1'b0); tx(1, 1'b1, 8'h92, 1'b0);
    exp_acc(21, 2'b01); exp_acc(25, 2'b10);
    exp_strobe(23, 1'b1, 8'h91, 2'b01); exp_strobe(27, 1'b1, 8'h92, 2'b10);
    goto(40);
    chk("strobes_left", 32'(exp_s.size()), 32'd0);
    chk("readies_left", 32'(exp_a.size()), 32'd0);
    finish_run();
  end
endmodule
